// File: rtl/bg_ctrl_pkg.sv
// Shared definitions for the bandgap trim controller: op codes, FSM states
// and frame-geometry helpers.
package bg_ctrl_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_TRIM = 2'b01;
  localparam logic [1:0] OP_EN   = 2'b10;
  localparam logic [1:0] OP_RB   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int ch_idx_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

  function automatic int frame_w(input int n_ch, input int trim_w);
    return 2 + ch_idx_w(n_ch) + trim_w;
  endfunction

endpackage

// File: rtl/bg_chopper.sv
// Chopper clock divider plus blanking counter that qualifies the
// reference-valid flag after any analog disturbance.
module bg_chopper #(
  parameter int CHOP_DIV = 256,
  parameter int BLANK    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_any_en,
  input  logic i_disturb,
  output logic o_chop,
  output logic o_vref_valid
);

  localparam int DIV_W = $clog2(CHOP_DIV);
  localparam int BLK_W = $clog2(BLANK + 1);

  logic [DIV_W-1:0] r_div;
  logic [BLK_W-1:0] r_blank;
  logic             r_chop;
  logic             w_wrap;

  assign w_wrap = i_any_en && (r_div == DIV_W'(CHOP_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_chop  <= 1'b0;
      r_blank <= '0;
    end else begin
      if (!i_any_en) begin
        r_div  <= '0;
        r_chop <= 1'b0;
      end else if (w_wrap) begin
        r_div  <= '0;
        r_chop <= ~r_chop;
      end else begin
        r_div <= r_div + 1'b1;
      end
      // A toggle and a disturbance in the same cycle reload only once.
      if (w_wrap || i_disturb)
        r_blank <= BLK_W'(BLANK);
      else if (r_blank != '0)
        r_blank <= r_blank - 1'b1;
    end
  end

  assign o_chop       = r_chop;
  assign o_vref_valid = (r_blank == '0) && i_any_en;

endmodule

// File: rtl/bandgap_trim_ctrl.sv
// Per-channel trim/enable registers loaded by a 3-wire serial frame, plus the
// shared chopper. Define BG_READBACK_EN to enable trim readback on sdo.
module bandgap_trim_ctrl
  import bg_ctrl_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int TRIM_W   = 4,
  parameter int TRIM_RST = 8,
  parameter int CHOP_DIV = 256,
  parameter int BLANK    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs_n,
  input  logic                     sclk,
  input  logic                     sdi,
  output logic                     sdo,
  output logic [N_CH*TRIM_W-1:0]   trim_o,
  output logic [N_CH-1:0]          en_o,
  output logic                     chop_o,
  output logic                     vref_valid_o,
  output logic                     frame_err_o
);

  localparam int CH_IDX_W = ch_idx_w(N_CH);
  localparam int FRAME_W  = frame_w(N_CH, TRIM_W);
  localparam int CNT_W    = $clog2(FRAME_W + 2);

  logic [1:0]             r_cs_s, r_sclk_s, r_sdi_s;
  logic                   r_sclk_d;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [FRAME_W-1:0]     r_shift;
  logic [N_CH*TRIM_W-1:0] r_trim;
  logic [N_CH-1:0]        r_en;
  logic                   r_err;

  logic                   w_cs, w_sdi, w_rise;
  logic [1:0]             w_op;
  logic [CH_IDX_W-1:0]    w_ch;
  logic [TRIM_W-1:0]      w_data;
  logic                   w_ch_ok, w_commit_ok, w_disturb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_s   <= 2'b11;
      r_sclk_s <= 2'b00;
      r_sdi_s  <= 2'b00;
      r_sclk_d <= 1'b0;
    end else begin
      r_cs_s   <= {r_cs_s[0], cs_n};
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_sdi_s  <= {r_sdi_s[0], sdi};
      r_sclk_d <= r_sclk_s[1];
    end
  end

  assign w_cs   = r_cs_s[1];
  assign w_sdi  = r_sdi_s[1];
  assign w_rise = r_sclk_s[1] & ~r_sclk_d;

  assign w_op        = r_shift[FRAME_W-1 -: 2];
  assign w_ch        = r_shift[TRIM_W +: CH_IDX_W];
  assign w_data      = r_shift[TRIM_W-1:0];
  assign w_ch_ok     = 32'(w_ch) < N_CH;
  assign w_commit_ok = (r_state == ST_COMMIT) && w_ch_ok;
  assign w_disturb   = w_commit_ok &&
                       ((w_op == OP_TRIM) ||
                        ((w_op == OP_EN) && (r_en[w_ch] != w_data[0])));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_trim  <= {N_CH{TRIM_W'(TRIM_RST)}};
      r_en    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_cs) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_cs) begin
            if (r_cnt == CNT_W'(FRAME_W)) begin
              r_state <= ST_COMMIT;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else if (w_rise && (r_cnt != CNT_W'(FRAME_W + 1))) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          if (!w_ch_ok) begin
            r_err <= 1'b1;
          end else begin
            r_err <= 1'b0;
            if (w_op == OP_TRIM) r_trim[w_ch*TRIM_W +: TRIM_W] <= w_data;
            if (w_op == OP_EN)   r_en[w_ch] <= w_data[0];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == ST_SHIFT) && !w_cs && w_rise)
      r_shift <= {r_shift[FRAME_W-2:0], w_sdi};
  end

`ifdef BG_READBACK_EN
  localparam int HDR_W = 2 + CH_IDX_W;

  logic [TRIM_W-1:0]   r_rb;
  logic                r_rb_act;
  logic                r_sdo;
  logic [HDR_W-1:0]    w_hdr;
  logic [CH_IDX_W-1:0] w_hdr_ch;

  // Header as it will stand once the current sdi bit is shifted in.
  assign w_hdr    = {r_shift[HDR_W-2:0], w_sdi};
  assign w_hdr_ch = w_hdr[CH_IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdo    <= 1'b0;
      r_rb_act <= 1'b0;
    end else if (r_state != ST_SHIFT) begin
      r_sdo    <= 1'b0;
      r_rb_act <= 1'b0;
    end else if (!w_cs && w_rise) begin
      if (r_cnt == CNT_W'(HDR_W - 1)) begin
        r_rb_act <= (w_hdr[HDR_W-1 -: 2] == OP_RB);
        r_rb     <= (32'(w_hdr_ch) < N_CH) ? r_trim[w_hdr_ch*TRIM_W +: TRIM_W] : '0;
      end else if (r_rb_act && (r_cnt < CNT_W'(FRAME_W))) begin
        r_sdo <= r_rb[TRIM_W-1];
        r_rb  <= r_rb << 1;
      end
    end
  end

  assign sdo = r_sdo;
`else
  assign sdo = 1'b0;
`endif

  bg_chopper #(
    .CHOP_DIV (CHOP_DIV),
    .BLANK    (BLANK)
  ) u_chopper (
    .clk          (clk),
    .rst          (rst),
    .i_any_en     (|r_en),
    .i_disturb    (w_disturb),
    .o_chop       (chop_o),
    .o_vref_valid (vref_valid_o)
  );

  assign trim_o      = r_trim;
  assign en_o        = r_en;
  assign frame_err_o = r_err;

endmodule

// File: tb/tb_bandgap_trim_ctrl.sv
// Directed plus randomized frame bench for bandgap_trim_ctrl with a
// frame-level reference model (N_CH=2, TRIM_W=4, CHOP_DIV=16, BLANK=4).
module tb_bandgap_trim_ctrl;

  logic       clk = 1'b0;
  logic       rst, cs_n, sclk, sdi;
  logic       sdo;
  logic [7:0] trim_o;
  logic [1:0] en_o;
  logic       chop_o, vref_valid_o, frame_err_o;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  m_trim [2];
  logic        m_en   [2];
  logic        m_err;
  logic [15:0] sdo_cap;

  bandgap_trim_ctrl #(
    .N_CH(2), .TRIM_W(4), .TRIM_RST(8), .CHOP_DIV(16), .BLANK(4)
  ) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .sdi(sdi), .sdo(sdo),
    .trim_o(trim_o), .en_o(en_o), .chop_o(chop_o),
    .vref_valid_o(vref_valid_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_trim_vec();
    return {m_trim[1], m_trim[0]};
  endfunction

  function automatic logic [1:0] m_en_vec();
    return {m_en[1], m_en[0]};
  endfunction

  task automatic model_reset();
    m_trim[0] = 4'h8; m_trim[1] = 4'h8;
    m_en[0] = 1'b0;   m_en[1] = 1'b0;
    m_err = 1'b0;
  endtask

  // Frame-level rule: wrong length or bad channel rejects, otherwise apply op.
  task automatic model_frame(input logic [6:0] f, input int n);
    logic [1:0] op;
    int         ch;
    logic [3:0] d;
    op = f[6:5]; ch = int'(f[4]); d = f[3:0];
    if (n != 7 || ch >= 2) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      if (op == 2'b01) m_trim[ch] = d;
      if (op == 2'b10) m_en[ch] = d[0];
    end
  endtask

  task automatic cs_low();
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int idx);
    sdi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sdo_cap[idx] = sdo;
    sclk = 1'b0;
  endtask

  // Returns 1 time unit after the commit edge (4th posedge after cs_n rises).
  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    sdo_cap = '0;
    cs_low();
    for (int i = 0; i < n; i++) send_bit(bits[n-1-i], i);
    cs_high();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_trim"}, 32'(trim_o), 32'(m_trim_vec()));
    chk({tag, "_en"},   32'(en_o),   32'(m_en_vec()));
    chk({tag, "_err"},  32'(frame_err_o), 32'(m_err));
  endtask

  initial begin
    logic [6:0] f;
    int         n;
    logic [3:0] rb;

    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset_chop",  32'(chop_o), 32'h0);
    chk("reset_valid", 32'(vref_valid_o), 32'h0);
    chk("reset_sdo",   32'(sdo), 32'h0);
    @(negedge clk); rst = 1'b0;

    f = 7'b0110011; send_frame(16'(f), 7); model_frame(f, 7);
    check_state("trim1");
    chk("trim1_trimval", 32'(trim_o), 32'h38);
    repeat (5) @(negedge clk);
    chk("trim1_valid", 32'(vref_valid_o), 32'h0);

    // Enable ch0 and track chop/valid against elapsed cycles since commit.
    f = 7'b1000001; send_frame(16'(f), 7); model_frame(f, 7);
    check_state("en0");
    for (int k = 0; k < 48; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      chk($sformatf("chop_k%0d", k),  32'(chop_o), 32'((k / 16) % 2));
      chk($sformatf("valid_k%0d", k), 32'(vref_valid_o), 32'((k % 16) >= 4));
    end

    send_frame(16'b010110, 6); model_frame(7'b0, 6);
    check_state("short6");

    f = 7'b0000000; send_frame(16'(f), 7); model_frame(f, 7);
    check_state("nop");

    f = 7'b1110000; send_frame(16'(f), 7); model_frame(f, 7);
    check_state("rb");
    rb = m_trim[1];
`ifndef BG_READBACK_EN
    rb = 4'h0;
`endif
    for (int j = 0; j < 4; j++)
      chk($sformatf("rb_sdo%0d", j), 32'(sdo_cap[3+j]), 32'(rb[3-j]));

    // Trim write while enabled must blank for at least BLANK samples.
    f = 7'b0100101; send_frame(16'(f), 7); model_frame(f, 7);
    check_state("trim_en");
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      chk($sformatf("blank_k%0d", k), 32'(vref_valid_o), 32'h0);
    end

    for (int t = 0; t < 20; t++) begin
      f = 7'($urandom_range(0, 127));
      case ($urandom_range(0, 5))
        0:       n = 6;
        1:       n = 8;
        default: n = 7;
      endcase
      send_frame(16'(f), n); model_frame(f, n);
      check_state($sformatf("rnd%0d", t));
      if (n == 7 && f[6:5] == 2'b11) begin
        rb = m_trim[int'(f[4])];
`ifndef BG_READBACK_EN
        rb = 4'h0;
`endif
        chk($sformatf("rnd%0d_sdo", t), 32'({sdo_cap[3], sdo_cap[4], sdo_cap[5], sdo_cap[6]}), 32'(rb));
      end
    end

    // Reset in the middle of a trim frame aborts it.
    f = 7'b0101111;
    cs_low();
    for (int i = 0; i < 4; i++) send_bit(f[6-i], i);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_state("midrst");
    chk("midrst_chop",  32'(chop_o), 32'h0);
    chk("midrst_valid", 32'(vref_valid_o), 32'h0);
    chk("midrst_sdo",   32'(sdo), 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 4; i < 7; i++) send_bit(f[6-i], i);
    cs_high();
    m_err = 1'b1;
    check_state("postrst");

    f = 7'b0000000; send_frame(16'(f), 7); model_frame(f, 7);
    check_state("final_nop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bandgap_trim_ctrl.md
Name: bandgap_trim_ctrl

Overview:
- Digital control block for the next-generation multi-channel bandgap references.
- Holds a per-channel trim code and enable, loaded over a 3-wire serial frame from dedicated input pins.
- Generates a common chopper clock for the output buffer amplifiers, plus a blanking-qualified valid flag.
- Sits between the top-level pins and the N_CH bandgap/buffer analog instances.

Parameters:
- N_CH, 2, number of bandgap channels; CH_IDX_W = max(1, clog2(N_CH)).
- TRIM_W, 4, trim code width per channel.
- TRIM_RST, 8, trim value after reset (mid-code); must fit in TRIM_W bits.
- CHOP_DIV, 256, clk cycles per chopper half-period; minimum 2.
- BLANK, 8, valid-blanking cycles after any analog disturbance; minimum 1.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset, synchronous, active-high.
- cs_n, in, 1, serial frame select, active-low, asynchronous to clk.
- sclk, in, 1, serial bit clock, asynchronous, much slower than clk.
- sdi, in, 1, serial data, MSB first.
- sdo, out, 1, serial readback data (see Optional Feature).
- trim_o, out, N_CH*TRIM_W, trim codes; channel k occupies bits [k*TRIM_W +: TRIM_W].
- en_o, out, N_CH, per-channel enable.
- chop_o, out, 1, chopper phase for all buffer amplifiers.
- vref_valid_o, out, 1, outputs settled.
- frame_err_o, out, 1, last frame was rejected.

Interface: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset values: trim_o = TRIM_RST on every channel; en_o = 0; chop_o = 0; vref_valid_o = 0; frame_err_o = 0; sdo = 0; FSM in IDLE; counters cleared.
- cs_n, sclk and sdi each pass through a 2-flop synchroniser.
- An sclk rise is detected when synced sclk is 1 and its previous value was 0. Edge-to-action latency is 3 clk cycles.
- Frame format, FRAME_W = 2 + CH_IDX_W + TRIM_W bits: op[1:0], ch[CH_IDX_W-1:0], data[TRIM_W-1:0], MSB first.
- Op codes: 00 = nop; 01 = write trim; 10 = write enable (en <= data[0]); 11 = readback.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on synced cs_n = 0, go to SHIFT and clear the bit counter.
  - SHIFT: each sclk rise shifts sdi in; the bit counter saturates at FRAME_W+1.
  - SHIFT, on synced cs_n = 1: if count == FRAME_W, go to COMMIT. Otherwise set frame_err_o and go to IDLE with no write.
  - COMMIT: lasts exactly 1 cycle and always returns to IDLE.
    - If ch >= N_CH: set frame_err_o, no write.
    - Otherwise: apply the op and clear frame_err_o (nop also clears it).
- A trim write updates trim_o in the COMMIT cycle and appears on the next clock edge.
- frame_err_o is sticky until the next valid commit.
- Reset during SHIFT or COMMIT aborts the frame; no write occurs.
- Chopper, while any en_o bit is 1:
  - Counter runs 0..CHOP_DIV-1.
  - chop_o toggles on the cycle the counter wraps.
- Chopper, while all en_o bits are 0: counter held at 0 and chop_o forced to 0.
- Blanking counter is loaded to BLANK on any of: chop_o toggle, committed trim write, or an en_o change. It decrements to 0.
- vref_valid_o = (blank counter == 0) AND (any en_o bit is 1).
- A trim write coinciding with a chop toggle reloads blanking once; there is no double extension.

Optional Feature:
- Macro BG_READBACK_EN.
- With the macro defined:
  - In SHIFT, once op == 11 and all ch bits are received, load the addressed channel's trim (0 if ch >= N_CH) into a readback register.
  - Each subsequent sclk rise drives the next bit MSB first onto sdo.
  - sdo returns to 0 in IDLE.
- Without the macro: sdo is tied to 0, and op 11 commits as a nop (no error).

Decomposition:
- Package bg_ctrl_pkg holds:
  - op-code localparams (OP_NOP, OP_TRIM, OP_EN, OP_RB);
  - FSM state enum;
  - functions ch_idx_w(N_CH) and frame_w(N_CH, TRIM_W).
- One sub-module, bg_chopper: divider, chop_o, blanking counter, vref_valid_o.
  - Inputs: any_en, disturb pulse.

Test Plan (N_CH=2, TRIM_W=4, so FRAME_W=7; CHOP_DIV=16, BLANK=4):
- Reset -> trim_o = 0x88, en_o = 0, chop_o = 0, vref_valid_o = 0, frame_err_o = 0.
- Frame 01_1_0011 -> trim_o = 0x38, frame_err_o = 0, vref_valid_o stays 0 (no channel enabled).
- Frame 10_0_0001, then run -> en_o = 01; chop_o toggles every 16 cycles; vref_valid_o low for 4 cycles after each toggle, high otherwise.
- 6-bit frame, then cs_n high -> frame_err_o = 1, trim_o unchanged. Next valid frame 00_0_0000 -> frame_err_o = 0.
- Assert rst after 4 bits of a trim frame -> all outputs return to reset values; the later cs_n rise causes no write.
- With BG_READBACK_EN: frame 11_1_0000 after trim ch1 = 0x3 -> sdo emits 0,0,1,1 on the last 4 sclk rises.
